// File: rtl/fft_frame_loader.sv
// Ping-pong loader: packs a serial complex stream into N-sample frames for the parallel FFT core.
// Define FFT_LOADER_BITREV_EN to store frames in bit-reversed (decimation-in-time) order.
module fft_frame_loader #(
   parameter  int N    = 8,
   parameter  int DW   = 32,
   localparam int LOGN = $clog2(N)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DW-1:0]     s_data_r,
   input  logic [DW-1:0]     s_data_i,
   input  logic              s_last,
   output logic [N*DW-1:0]   frame_x_r,
   output logic [N*DW-1:0]   frame_x_i,
   output logic [LOGN:0]     frame_len,
   output logic              frame_valid,
   input  logic              frame_ack,
   output logic              sync_err
);

   logic [DW-1:0]   mem_r [2][N];
   logic [DW-1:0]   mem_i [2][N];
   logic            wr_bank, rd_bank;
   logic [LOGN:0]   wr_cnt;
   logic [1:0]      bank_full;
   logic [LOGN:0]   bank_len [2];
   logic            accept, last_slot, close, ack;
   logic [LOGN-1:0] waddr;

   assign s_ready     = !reset && !bank_full[wr_bank];
   assign accept      = s_valid && s_ready;
   assign last_slot   = (wr_cnt == (LOGN+1)'(N-1));
   assign close       = accept && (s_last || last_slot);
   assign ack         = frame_ack && bank_full[rd_bank];
   assign frame_valid = bank_full[rd_bank];
   assign frame_len   = frame_valid ? bank_len[rd_bank] : '0;

`ifdef FFT_LOADER_BITREV_EN
   always_comb begin
      waddr = '0;
      for (int b = 0; b < LOGN; b++) waddr[b] = wr_cnt[LOGN-1-b];
   end
`else
   assign waddr = wr_cnt[LOGN-1:0];
`endif

   // Sample storage has no reset; stale entries are hidden by the length mask below.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_r[wr_bank][waddr] <= s_data_r;
         mem_i[wr_bank][waddr] <= s_data_i;
      end
   end

   // Close and ack never target the same bank: the write bank is never full.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_cnt      <= '0;
         bank_full   <= '0;
         bank_len[0] <= '0;
         bank_len[1] <= '0;
         sync_err    <= 1'b0;
      end else begin
         sync_err <= close && last_slot && !s_last;
         if (accept) wr_cnt <= close ? '0 : wr_cnt + 1'b1;
         if (close) begin
            bank_full[wr_bank] <= 1'b1;
            bank_len[wr_bank]  <= wr_cnt + 1'b1;
            wr_bank            <= !wr_bank;
         end
         if (ack) begin
            bank_full[rd_bank] <= 1'b0;
            rd_bank            <= !rd_bank;
         end
      end
   end

   for (genvar p = 0; p < N; p++) begin : g_out
      localparam logic [LOGN-1:0] POS = LOGN'(p);
      logic [LOGN-1:0] nat;
      logic            keep;
`ifdef FFT_LOADER_BITREV_EN
      for (genvar b = 0; b < LOGN; b++) begin : g_rev
         assign nat[b] = POS[LOGN-1-b];
      end
`else
      assign nat = POS;
`endif
      // Position p holds natural sample nat; zero it when beyond the frame length.
      assign keep = frame_valid && ({1'b0, nat} < bank_len[rd_bank]);
      assign frame_x_r[p*DW +: DW] = keep ? mem_r[rd_bank][POS] : '0;
      assign frame_x_i[p*DW +: DW] = keep ? mem_i[rd_bank][POS] : '0;
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomized bench for fft_frame_loader checked every cycle against a queue-based frame model.
module tb_fft_frame_loader;
   localparam int N    = 8;
   localparam int DW   = 32;
   localparam int LOGN = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DW-1:0]     s_data_r = '0;
   logic [DW-1:0]     s_data_i = '0;
   logic              s_last = 1'b0;
   logic [N*DW-1:0]   frame_x_r, frame_x_i;
   logic [LOGN:0]     frame_len;
   logic              frame_valid;
   logic              frame_ack = 1'b0;
   logic              sync_err;

   fft_frame_loader #(.N(N), .DW(DW)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
      .s_data_r(s_data_r), .s_data_i(s_data_i), .s_last(s_last),
      .frame_x_r(frame_x_r), .frame_x_i(frame_x_i), .frame_len(frame_len),
      .frame_valid(frame_valid), .frame_ack(frame_ack), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N*DW-1:0] r;
      logic [N*DW-1:0] i;
      int              len;
   } frame_t;

   frame_t        held[$];
   logic [DW-1:0] cur_r[$];
   logic [DW-1:0] cur_i[$];
   logic          m_sync = 1'b0;
   int            tests = 0, fails = 0;
   bit            chk_en = 1'b0;
   int            ack_mode = 0;
   int            sync_cnt = 0;

   // Natural sample index that lands at output position p.
   function automatic int nat_of(int p);
`ifdef FFT_LOADER_BITREV_EN
      int k = 0;
      for (int b = 0; b < LOGN; b++) if ((p >> b) & 1) k |= 1 << (LOGN-1-b);
      return k;
`else
      return p;
`endif
   endfunction

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_w(string name, logic [N*DW-1:0] act, logic [N*DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: frames are whole objects in an arrival-ordered queue, at most two held.
   always @(posedge clk) begin
      bit     rdy, do_ack;
      frame_t f;
      rdy    = held.size() < 2;
      do_ack = frame_ack && held.size() > 0;
      if (reset) begin
         cur_r.delete(); cur_i.delete(); held.delete();
         m_sync = 1'b0;
      end else begin
         m_sync = 1'b0;
         if (do_ack) void'(held.pop_front());
         if (s_valid && rdy) begin
            cur_r.push_back(s_data_r);
            cur_i.push_back(s_data_i);
            if (s_last || cur_r.size() == N) begin
               f.len = cur_r.size();
               f.r = '0;
               f.i = '0;
               for (int p = 0; p < N; p++)
                  if (nat_of(p) < f.len) begin
                     f.r[p*DW +: DW] = cur_r[nat_of(p)];
                     f.i[p*DW +: DW] = cur_i[nat_of(p)];
                  end
               m_sync = !s_last && (f.len == N);
               held.push_back(f);
               cur_r.delete(); cur_i.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      frame_t h;
      if (chk_en) begin
         h.r = '0; h.i = '0; h.len = 0;
         if (held.size() > 0) h = held[0];
         chk("s_ready", int'(s_ready), int'(!reset && held.size() < 2));
         chk("frame_valid", int'(frame_valid), int'(held.size() > 0));
         chk("frame_len", int'(frame_len), h.len);
         chk("sync_err", int'(sync_err), int'(m_sync));
         chk_w("frame_x_r", frame_x_r, h.r);
         chk_w("frame_x_i", frame_x_i, h.i);
         if (sync_err === 1'b1) sync_cnt++;
      end
   end

   always @(posedge clk) begin
      #2;
      case (ack_mode)
         1:       frame_ack = frame_valid;
         2:       frame_ack = 1'($urandom_range(0, 1));
         default: frame_ack = 1'b0;
      endcase
   end

   task automatic align();
      @(posedge clk); #1;
   endtask

   task automatic send(logic [DW-1:0] r, logic [DW-1:0] i, bit last, output int stalls);
      int budget = 0;
      stalls = 0;
      s_valid = 1'b1; s_data_r = r; s_data_i = i; s_last = last;
      @(negedge clk);
      while (!s_ready && budget < 300) begin
         stalls++; budget++;
         @(negedge clk);
      end
      if (!s_ready) begin
         tests++; fails++;
         $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
      end
      align();
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic ack_one();
      ack_mode = 1;
      align(); align();
      ack_mode = 0;
      align();
   endtask

   initial begin
      int st, tot, gap;
      logic [N*DW-1:0] expv;
      int bitrev_exp[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      align();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready_after", int'(s_ready), 1);
      chk("rst_valid", int'(frame_valid), 0);
      chk_w("rst_x_r", frame_x_r, '0);
      align();

      // full frame with s_last on the 8th sample
      sync_cnt = 0;
      for (int k = 0; k < N; k++) send(DW'(k+1), DW'(-(k+1)), k == N-1, st);
      @(negedge clk);
      chk("t1_valid", int'(frame_valid), 1);
      chk("t1_len", int'(frame_len), 8);
      expv = '0;
      for (int p = 0; p < N; p++) expv[p*DW +: DW] = DW'(nat_of(p) + 1);
      chk_w("t1_x_r", frame_x_r, expv);
      chk("t1_no_sync", sync_cnt, 0);
      align();
      ack_one();

      // overrun close without s_last
      sync_cnt = 0;
      for (int k = 0; k < N; k++) send(DW'(100+k), DW'(k), 1'b0, st);
      @(negedge clk);
      @(negedge clk);
      chk("t2_sync_once", sync_cnt, 1);
      align();
      ack_one();

      // short frame after a saturated frame
      for (int k = 0; k < N; k++) send(32'h7FFF_FFFF, 32'h7FFF_FFFF, k == N-1, st);
      ack_one();
      for (int k = 0; k < 3; k++) send(DW'(10*(k+1)), DW'(k), k == 2, st);
      @(negedge clk);
      chk("t3_len", int'(frame_len), 3);
      expv = '0;
      for (int p = 0; p < N; p++)
         if (nat_of(p) < 3) expv[p*DW +: DW] = DW'(10*(nat_of(p)+1));
      chk_w("t3_x_r", frame_x_r, expv);
      align();
      ack_one();

      // back-pressure: both banks fill, sample 17 held
      ack_mode = 0;
      for (int k = 0; k < 16; k++) send(DW'(k+1), DW'(k+1000), k % 8 == 7, st);
      s_valid = 1'b1; s_data_r = DW'(17); s_data_i = DW'(1016); s_last = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t4_stalled", int'(s_ready), 0);
      end
      ack_mode = 1;
      align();
      for (int k = 16; k < 24; k++) send(DW'(k+1), DW'(k+1000), k % 8 == 7, st);
      repeat (4) align();

      // sustained throughput with immediate acks
      tot = 0;
      for (int k = 0; k < 40; k++) begin
         send(DW'($urandom), DW'($urandom), k % 8 == 7, st);
         tot += st;
      end
      chk("t5_no_stall", tot, 0);
      repeat (4) align();

      // reset mid-frame with the other bank held
      ack_mode = 0;
      for (int k = 0; k < N; k++) send(DW'($urandom), DW'($urandom), k == N-1, st);
      for (int k = 0; k < 5; k++) send(DW'($urandom), DW'($urandom), 1'b0, st);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t6_valid_rst", int'(frame_valid), 0);
      chk_w("t6_x_r_rst", frame_x_r, '0);
      chk("t6_len_rst", int'(frame_len), 0);
      align();
      reset = 1'b0;
      for (int k = 0; k < N; k++) send(DW'(k), DW'(0), k == N-1, st);
      @(negedge clk);
      expv = '0;
`ifdef FFT_LOADER_BITREV_EN
      for (int p = 0; p < N; p++) expv[p*DW +: DW] = DW'(bitrev_exp[p]);
`else
      for (int p = 0; p < N; p++) expv[p*DW +: DW] = DW'(p);
`endif
      chk_w("t6_x_r_order", frame_x_r, expv);
      align();
      ack_one();

      // random traffic, random acks, random frame lengths and gaps
      ack_mode = 2;
      for (int k = 0; k < 300; k++) begin
         send(DW'($urandom), DW'($urandom), $urandom_range(0, 5) == 0, st);
         gap = $urandom_range(0, 2);
         repeat (gap) align();
      end
      ack_mode = 1;
      repeat (10) align();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation time exceeded");
      $fatal(1);
   end
endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Upstream neighbour of the parallel FFT core. Accepts a serial stream of complex samples through a valid/ready handshake and packs each N-sample frame into one of two ping-pong banks.
- Presents a completed frame as flat parallel real/imag buses, with frame_valid/frame_ack, for the FFT core to consume.
- Absorbs rate mismatch: one frame can fill while the previous one is held for the FFT.

Parameters:
- N, 8, frame length; power of two, 4..64.
- DW, 32, sample width per component, signed two's complement.
- LOGN, $clog2(N), index width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample.
- s_data_r  in  DW  sample real part.
- s_data_i  in  DW  sample imaginary part.
- s_last  in  1  final sample of frame; may arrive early for a short frame.
- frame_x_r  out  N*DW  frame real parts; element k at bits [k*DW +: DW].
- frame_x_i  out  N*DW  frame imaginary parts, same packing.
- frame_len  out  LOGN+1  number of real samples in the presented frame, 1..N.
- frame_valid  out  1  presented frame is complete and stable.
- frame_ack  in  1  consumer releases the presented frame.
- sync_err  out  1  one-cycle pulse: frame closed at N samples without s_last.

Behaviour:
- State:
  - mem[2][N] complex entries.
  - wr_bank and rd_bank pointers (1 bit each).
  - wr_cnt (LOGN+1 bits).
  - bank_full[2].
  - bank_len[2].
- Reset (synchronous, high): wr_bank=rd_bank=0, wr_cnt=0, bank_full=0, bank_len=0, sync_err=0. Memory contents are don't-care.
- Reset mid-operation: any partial frame is discarded and any held frame is dropped. frame_valid=0 on the edge after reset is sampled.
- Output values during and after reset:
  - s_ready=0 while reset is high; s_ready=1 on the first cycle after reset deasserts.
  - frame_x_r/frame_x_i are all zero while frame_valid=0.
  - frame_len=0 while frame_valid=0.
- s_ready = !reset && !bank_full[wr_bank]. Combinational, with no dependence on s_valid.
- Accept: s_valid && s_ready at a clock edge.
  - The sample is written to mem[wr_bank][addr(wr_cnt)].
  - addr(k) = k in natural order.
  - wr_cnt increments.
- Frame close: on an accept with s_last=1 or wr_cnt==N-1:
  - bank_full[wr_bank] <= 1 and bank_len[wr_bank] <= wr_cnt+1.
  - wr_bank toggles and wr_cnt <= 0.
  - sync_err pulses for one cycle when the frame closes with wr_cnt==N-1 and s_last==0.
  - s_last together with wr_cnt==N-1 is a normal close.
- Short frame: entries at natural index >= bank_len are presented as zero (zero padding). Stale memory is never visible.
- frame_valid = bank_full[rd_bank]. It is registered-state derived, so it rises the cycle after the closing accept edge.
  - Latency from the last sample accepted to frame_valid is 1 cycle.
- While frame_valid=1:
  - frame_x_r/frame_x_i = mem[rd_bank], masked as above.
  - frame_len = bank_len[rd_bank].
  - All held stable until ack.
- Ack: frame_ack && frame_valid at an edge clears bank_full[rd_bank] and toggles rd_bank. frame_ack while frame_valid=0 is ignored.
- Both banks full: s_ready=0, and the stream stalls until an ack.
- Simultaneous ack and frame close in the same cycle: both take effect.
  - Full throughput is one sample per cycle, with no bubble at frame boundaries.
  - Frames are presented strictly in arrival order.
- s_valid with s_ready=0: no state change, and the sample must be held by the source.
- Ordering of memory reads: ack of bank B and a write into bank B in the same cycle cannot occur, because the write bank is never full.

Optional Feature:
- Macro: FFT_LOADER_BITREV_EN.
- Defined: addr(k) = bit-reverse of k over LOGN bits, so the frame is presented in decimation-in-time input order.
  - Zero mask: output position p is zero when bitrev(p) >= bank_len.
  - frame_len is still the count of natural samples.
- Undefined: natural order; the reversal logic is not synthesised.

Test Plan:
1. Reset, then 8 accepts (real=k+1, imag=-(k+1)), s_last on the 8th → frame_valid rises 1 cycle after the 8th accept. frame_x_r element k = k+1, frame_len=8, sync_err never pulses.
2. 8 samples with no s_last → frame closes, sync_err pulses exactly once, coincident with the frame_valid rise.
3. 3 samples (10, 20, 30), s_last on the 3rd → frame_len=3. Elements 0..2 = 10, 20, 30; elements 3..7 = 0. Repeat after a full frame of 0x7FFFFFFF to prove no stale data.
4. Continuous s_valid for 24 samples, frame_ack held low → s_ready drops after sample 16, and sample 17 is held. Ack frame 0 → s_ready=1 next cycle; frames are delivered 0, 1, 2 in order with no lost or duplicated sample.
5. Continuous stream with frame_ack pulsed the cycle frame_valid rises → one sample per cycle sustained, with s_ready never low.
6. Reset asserted after sample 5 of a frame with the other bank full → frame_valid=0 and all outputs zero. A new 8-sample frame afterwards contains only the new data. With FFT_LOADER_BITREV_EN and inputs 0..7, frame_x_r = 0, 4, 2, 6, 1, 5, 3, 7.
